arcade_input: RTL
=================

Name: arcade_input

Overview:
- Parametrised player-input and configuration front end between hps_io and the game core.
- Merges PS/2 keyboard events with per-player HPS joystick words into registered per-player direction/button/start/coin vectors.
- Adds opposite-direction cleaning, fixed-width coin pulses and a pause toggle.
- Captures DIP switch banks and the game index from ioctl download traffic.

Parameters:
- NUM_PLAYERS, 2, player count (1..4); keyboard map covers players 1-2, players 3-4 are joystick-only.
- NUM_BUTTONS, 4, fire buttons per player (1..6).
- NUM_DIP, 2, number of 8-bit DIP banks (1..8).
- COIN_HOLD, 16, coin pulse width in clk cycles (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ps2_key  in  11  hps_io key event: [10] toggle, [9] pressed, [8] extended, [7:0] scan code.
- joystick  in  NUM_PLAYERS*16  per-player HPS joystick word, player p at [16p+15:16p]; bit0 right, 1 left, 2 down, 3 up, 4..3+NUM_BUTTONS buttons, 4+NUM_BUTTONS start, 5+NUM_BUTTONS coin.
- ioctl_addr  in  25  download address.
- ioctl_data  in  8  download byte.
- ioctl_wr  in  1  download write strobe.
- ioctl_index  in  8  download index.
- joy  out  NUM_PLAYERS*4  per player {up,down,right,left}.
- buttons  out  NUM_PLAYERS*NUM_BUTTONS  per-player fire buttons, button 0 at LSB.
- start  out  NUM_PLAYERS  start per player.
- coin  out  NUM_PLAYERS  coin pulse per player.
- pause  out  1  pause state.
- dip  out  NUM_DIP*8  DIP banks, bank 0 at LSB.
- game_index  out  4  selected game.

Behaviour:
- Reset:
  - All outputs and all internal key, counter and edge registers are 0.
  - reset_n is driven from PLL lock only, so game reset does not clear DIP banks or the game index.
- PS/2 event detection:
  - old_toggle is registered each cycle.
  - An event occurs when ps2_key[10] != old_toggle.
  - On an event, the key register matching ps2_key[7:0] loads ps2_key[9]; ps2_key[8] is ignored.
  - Unmapped codes are ignored.
  - Only one key register updates per event.
- Key map, player 1:
  - up 75, down 72, left 6B, right 74.
  - buttons 14, 11, 29, 12, 1A, 22.
  - start 16, coin 2E.
- Key map, player 2:
  - up 2D, down 2B, left 23, right 34.
  - buttons 1C, 1B, 15, 1D, 24, 2C.
  - start 1E, coin 36.
- Pause key: 4D. Only the first NUM_BUTTONS button codes per player are used.
- Merge:
  - raw = key | joystick bit.
  - Opposite-direction cleaning: up&down both asserted gives both 0; left&right both asserted gives both 0.
  - joy, buttons and start are registered, one cycle after the merged input.
  - Latency: joystick change to output is 1 edge; ps2 toggle to output is 2 edges.
- Coin, per player:
  - Rising edge of raw coin while the counter is 0 loads COIN_HOLD.
  - coin output = (counter != 0), registered.
  - The counter decrements to 0.
  - Edges while the counter is non-zero are ignored (no retrigger).
  - A held coin produces exactly one pulse; a new pulse needs release and press.
  - Pulse starts 1 edge after the raw rising edge and lasts exactly COIN_HOLD cycles.
- Pause:
  - Toggles on a PS/2 press event of code 4D.
  - Release events and auto-repeat presses with pause already toggled in the same key-down are ignored; a pause key register tracks the held state.
- DIP capture:
  - ioctl_wr && ioctl_index==254 && ioctl_addr < NUM_DIP writes dip bank [ioctl_addr[2:0]] <= ioctl_data on the same edge.
  - Out-of-range addresses are ignored.
- Game index: ioctl_wr && ioctl_index==1 loads game_index <= ioctl_data[3:0].
- Simultaneous PS/2 event and ioctl write: both take effect; the paths are independent.
- Asynchronous reset mid-pulse clears counters and coin output immediately.

Decomposition:
- Package arcade_input_pkg:
  - scan-code localparams for both player maps and the pause key.
  - joystick bit index functions (button i = 4+i; start/coin offsets from NUM_BUTTONS).
  - DIP_INDEX=254, GAME_INDEX=1.
- Sub-module coin_pulse: one per player; parameter COIN_HOLD; ports clk, reset_n, in, out.

Test Plan:
- Keyboard press: reset, then toggle ps2_key[10] with {pressed=1, code 75} -> joy[3] (P1 up) =1 two edges later. Toggle again with pressed=0 -> 0 two edges later.
- Opposite-direction cleaning: joystick[1:0]=2'b11 -> joy[1:0]=00. Key 6B held plus joystick[0] -> 00. Release right -> joy[0]=1 (left).
- Coin pulse: COIN_HOLD=16, hold joystick P2 coin high for 100 cycles -> coin[1] high exactly 16 cycles, starting 1 edge after assertion, once only. Release and re-press -> second 16-cycle pulse.
- Pause: press/release 4D twice, including a repeated press event without a release -> pause 0->1 on the first press only, 1->0 on the second key-down.
- DIP and game index: NUM_DIP=2, write 0xA5@0 and 0x3C@1 on index 254, 0xFF@2 on index 254, 0x07 on index 1 -> dip=16'h3CA5, game_index=7. Pulse reset_n low -> all outputs 0.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input front end: scan-code maps, ioctl indices
// and the bit layout of the per-player joystick word.
package arcade_input_pkg;

    localparam logic [7:0] DIP_INDEX  = 8'd254;
    localparam logic [7:0] GAME_INDEX = 8'd1;
    localparam logic [7:0] KEY_PAUSE  = 8'h4D;

    // Directions packed {up, down, left, right} so byte k matches joystick bit k.
    localparam logic [31:0] P1_DIRS = {8'h75, 8'h72, 8'h6B, 8'h74};
    localparam logic [31:0] P2_DIRS = {8'h2D, 8'h2B, 8'h23, 8'h34};
    localparam logic [47:0] P1_BTNS = {8'h22, 8'h1A, 8'h12, 8'h29, 8'h11, 8'h14};
    localparam logic [47:0] P2_BTNS = {8'h2C, 8'h24, 8'h1D, 8'h15, 8'h1B, 8'h1C};
    localparam logic [15:0] P1_SYS  = {8'h2E, 8'h16};
    localparam logic [15:0] P2_SYS  = {8'h36, 8'h1E};

    function automatic int btn_bit(int i);
        return 4 + i;
    endfunction

    function automatic int start_bit(int nb);
        return 4 + nb;
    endfunction

    function automatic int coin_bit(int nb);
        return 5 + nb;
    endfunction

    // Returns {mapped, scan_code} for joystick-layout bit k of player p.
    function automatic logic [8:0] key_code(int p, int k, int nb);
        logic [31:0] dirs;
        logic [47:0] btns;
        logic [15:0] sys;
        dirs = '0;
        btns = '0;
        sys  = '0;
        if (p == 0) begin
            dirs = P1_DIRS; btns = P1_BTNS; sys = P1_SYS;
        end else if (p == 1) begin
            dirs = P2_DIRS; btns = P2_BTNS; sys = P2_SYS;
        end else begin
            return 9'h000;
        end
        if (k < 4)             return {1'b1, dirs[8*k +: 8]};
        if (k < btn_bit(nb))   return {1'b1, btns[8*(k-4) +: 8]};
        if (k == start_bit(nb)) return {1'b1, sys[7:0]};
        if (k == coin_bit(nb))  return {1'b1, sys[15:8]};
        return 9'h000;
    endfunction

endpackage

// File: rtl/arcade_input_if.sv
// ioctl download bus from hps_io into the input front end.
interface arcade_input_if;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;

    modport master (output ioctl_addr, ioctl_data, ioctl_wr, ioctl_index);
    modport slave  (input  ioctl_addr, ioctl_data, ioctl_wr, ioctl_index);
endinterface

// File: rtl/arcade_input_coin.sv
// Fixed-width, non-retriggerable coin pulse from a raw coin level.
module coin_pulse #(
    parameter int COIN_HOLD = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic out
);
    localparam int CW = $clog2(COIN_HOLD + 1);

    logic          in_q;
    logic          out_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Rising edges are only honoured once the previous pulse has fully drained.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
        else if (in && !in_q)
            cnt_d = CW'(COIN_HOLD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q  <= 1'b0;
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            in_q  <= in;
            cnt_q <= cnt_d;
            out_q <= (cnt_d != '0);
        end
    end

    assign out = out_q;
endmodule

// File: rtl/arcade_input.sv
// Merges PS/2 keys and HPS joysticks into registered player controls; captures
// DIP banks and the game index from ioctl downloads.
module arcade_input
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BUTTONS = 4,
    parameter int NUM_DIP     = 2,
    parameter int COIN_HOLD   = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [10:0]                      ps2_key,
    input  logic [NUM_PLAYERS*16-1:0]        joystick,
    arcade_input_if.slave                    ioctl,
    output logic [NUM_PLAYERS*4-1:0]         joy,
    output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] buttons,
    output logic [NUM_PLAYERS-1:0]           start,
    output logic [NUM_PLAYERS-1:0]           coin,
    output logic                             pause,
    output logic [NUM_DIP*8-1:0]             dip,
    output logic [3:0]                       game_index
);
    localparam int NKEY  = 6 + NUM_BUTTONS;
    localparam int START = start_bit(NUM_BUTTONS);
    localparam int COIN  = coin_bit(NUM_BUTTONS);

    logic                              old_toggle_q;
    logic                              ps2_event;
    logic [NKEY-1:0]                   key_q [NUM_PLAYERS];
    logic [NKEY-1:0]                   key_d [NUM_PLAYERS];
    logic [NKEY-1:0]                   raw   [NUM_PLAYERS];
    logic                              pause_key_q, pause_key_d;
    logic                              pause_q, pause_d;
    logic [NUM_PLAYERS*4-1:0]          joy_q, joy_d;
    logic [NUM_PLAYERS*NUM_BUTTONS-1:0] buttons_q, buttons_d;
    logic [NUM_PLAYERS-1:0]            start_q, start_d;
    logic [3:0]                        game_index_q;
    logic                              unused_ext;

    assign ps2_event  = ps2_key[10] ^ old_toggle_q;
    assign unused_ext = ps2_key[8];

    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++)
            key_d[p] = key_q[p];
        pause_key_d = pause_key_q;
        pause_d     = pause_q;
        if (ps2_event) begin
            for (int p = 0; p < NUM_PLAYERS; p++)
                for (int k = 0; k < NKEY; k++)
                    if (key_code(p, k, NUM_BUTTONS) == {1'b1, ps2_key[7:0]})
                        key_d[p][k] = ps2_key[9];
            // Only the first key-down toggles; auto-repeat presses see pause_key_q set.
            if (ps2_key[7:0] == KEY_PAUSE) begin
                pause_key_d = ps2_key[9];
                if (ps2_key[9] && !pause_key_q)
                    pause_d = ~pause_q;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        assign raw[gi] = key_q[gi] | joystick[16*gi +: NKEY];
        assign joy_d[4*gi +: 4] = {raw[gi][3] & ~raw[gi][2], raw[gi][2] & ~raw[gi][3],
                                   raw[gi][0] & ~raw[gi][1], raw[gi][1] & ~raw[gi][0]};
        assign buttons_d[NUM_BUTTONS*gi +: NUM_BUTTONS] = raw[gi][4 +: NUM_BUTTONS];
        assign start_d[gi] = raw[gi][START];

        coin_pulse #(.COIN_HOLD(COIN_HOLD)) u_coin (
            .clk     (clk),
            .reset_n (reset_n),
            .in      (raw[gi][COIN]),
            .out     (coin[gi])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            old_toggle_q <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++)
                key_q[p] <= '0;
            pause_key_q  <= 1'b0;
            pause_q      <= 1'b0;
            joy_q        <= '0;
            buttons_q    <= '0;
            start_q      <= '0;
            game_index_q <= '0;
        end else begin
            old_toggle_q <= ps2_key[10];
            for (int p = 0; p < NUM_PLAYERS; p++)
                key_q[p] <= key_d[p];
            pause_key_q <= pause_key_d;
            pause_q     <= pause_d;
            joy_q       <= joy_d;
            buttons_q   <= buttons_d;
            start_q     <= start_d;
            if (ioctl.ioctl_wr && ioctl.ioctl_index == GAME_INDEX)
                game_index_q <= ioctl.ioctl_data[3:0];
        end
    end

    // Full-address match per bank, so out-of-range addresses never alias a bank.
    for (genvar gi = 0; gi < NUM_DIP; gi++) begin : g_dip
        logic [7:0] bank_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                bank_q <= '0;
            else if (ioctl.ioctl_wr && ioctl.ioctl_index == DIP_INDEX &&
                     ioctl.ioctl_addr == 25'(gi))
                bank_q <= ioctl.ioctl_data;
        end
        assign dip[8*gi +: 8] = bank_q;
    end

    assign joy        = joy_q;
    assign buttons    = buttons_q;
    assign start      = start_q;
    assign pause      = pause_q;
    assign game_index = game_index_q;
endmodule
